// File: rtl/flp_add_sched_pkg.sv
// flp_add_sched_pkg: shared width helpers for the FP adder scheduler
package flp_add_sched_pkg;
  localparam int FLP_NREQ_MAX = 16;
  function automatic int flp_fwidth(int ewidth, int swidth);
    return 1 + ewidth + swidth;
  endfunction
  function automatic int flp_idw(int nreq);
    return nreq > 1 ? $clog2(nreq) : 1;
  endfunction
endpackage

// File: rtl/flp_add_sched_if.sv
// flp_add_sched_if: requester, adder and response signals of the scheduler
interface flp_add_sched_if #(
  parameter int NREQ   = 4,
  parameter int FWIDTH = 32,
  parameter int IDW    = 2
);
  logic [NREQ-1:0]        i_req_valid;
  logic [NREQ*FWIDTH-1:0] i_req_a;
  logic [NREQ*FWIDTH-1:0] i_req_b;
  logic [NREQ-1:0]        o_req_ready;
  logic [FWIDTH-1:0]      o_add_a;
  logic [FWIDTH-1:0]      o_add_b;
  logic                   o_add_valid;
  logic [FWIDTH-1:0]      i_add_p;
  logic [NREQ-1:0]        o_rsp_valid;
  logic [FWIDTH-1:0]      o_rsp_p;
  logic [IDW-1:0]         o_rsp_id;
  logic                   o_idle;
  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_add_p,
    output o_req_ready, o_add_a, o_add_b, o_add_valid, o_rsp_valid, o_rsp_p, o_rsp_id, o_idle
  );
  modport master (
    output i_req_valid, i_req_a, i_req_b, i_add_p,
    input  o_req_ready, o_add_a, o_add_b, o_add_valid, o_rsp_valid, o_rsp_p, o_rsp_id, o_idle
  );
endinterface

// File: rtl/flp_sched_arb.sv
// flp_sched_arb: one-hot grant arbiter; round-robin when FLP_ADD_SCHED_RR_EN is defined,
// lowest-index fixed priority otherwise
module flp_sched_arb import flp_add_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW  = flp_idw(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            acc_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o
);
  int base;
  logic found;
  logic [IDW-1:0] idx;
`ifdef FLP_ADD_SCHED_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;
  assign ptr_d = acc_i ? gnt_id_o : ptr_q;
  always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
  assign base = int'(ptr_q) + 1;
`else
  logic unused_ok;
  assign unused_ok = ^{clk, acc_i};
  assign base = 0;
`endif
  // search wraps modulo NREQ starting at base; nothing is granted while in reset
  always_comb begin
    gnt_o = '0;
    gnt_id_o = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((base + i) % NREQ);
      if (!found && !rst && req_i[idx]) begin
        found = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o = idx;
      end
    end
  end
endmodule

// File: rtl/flp_add_sched.sv
// flp_add_sched: shares one fixed-latency FP adder among NREQ requesters and routes sums back;
// FLP_ADD_SCHED_RR_EN selects round-robin arbitration in flp_sched_arb
module flp_add_sched import flp_add_sched_pkg::*; #(
  parameter int NREQ    = 4,
  parameter int EWIDTH  = 8,
  parameter int SWIDTH  = 23,
  parameter int LATENCY = 3,
  parameter int IDW     = flp_idw(NREQ)
) (
  input logic clk,
  input logic rst,
  flp_add_sched_if.slave bus
);
  localparam int FWIDTH = flp_fwidth(EWIDTH, SWIDTH);
  localparam int CW = $clog2(LATENCY + 2);
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] gid;
  logic acc;
  logic av_q;
  logic [FWIDTH-1:0] a_q, b_q;
  logic [IDW-1:0] id_q;
  logic tv;
  logic [IDW-1:0] tid;
  logic [CW-1:0] cnt_q, cnt_d;
  assign acc = |(bus.i_req_valid & gnt);
  flp_sched_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk(clk),
    .rst(rst),
    .req_i(bus.i_req_valid),
    .acc_i(acc),
    .gnt_o(gnt),
    .gnt_id_o(gid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      av_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      id_q <= '0;
    end else begin
      av_q <= acc;
      if (acc) begin
        a_q <= bus.i_req_a[gid*FWIDTH +: FWIDTH];
        b_q <= bus.i_req_b[gid*FWIDTH +: FWIDTH];
        id_q <= gid;
      end
    end
  end
  // tag IDs only advance behind a valid, so the pipe output holds the last responder's ID
  if (LATENCY == 0) begin : g_comb
    assign tv = av_q;
    assign tid = id_q;
  end else begin : g_pipe
    logic [LATENCY-1:0] v_q;
    logic [IDW-1:0] t_q [LATENCY];
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= '0;
        for (int i = 0; i < LATENCY; i++) t_q[i] <= '0;
      end else begin
        v_q[0] <= av_q;
        if (av_q) t_q[0] <= id_q;
        for (int i = 1; i < LATENCY; i++) begin
          v_q[i] <= v_q[i-1];
          if (v_q[i-1]) t_q[i] <= t_q[i-1];
        end
      end
    end
    assign tv = v_q[LATENCY-1];
    assign tid = t_q[LATENCY-1];
  end
  assign cnt_d = cnt_q + CW'(acc) - CW'(tv);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign bus.o_req_ready = gnt;
  assign bus.o_add_valid = av_q;
  assign bus.o_add_a = a_q;
  assign bus.o_add_b = b_q;
  assign bus.o_rsp_valid = {{(NREQ-1){1'b0}}, tv} << tid;
  assign bus.o_rsp_p = bus.i_add_p;
  assign bus.o_rsp_id = tid;
  assign bus.o_idle = cnt_q == '0;
endmodule

// File: tb/tb_flp_add_sched.sv
// tb_flp_add_sched: directed stimulus with a response scoreboard for flp_add_sched (LATENCY=3)
module tb_flp_add_sched;
  localparam int NREQ = 4;
  localparam int FW = 32;
  localparam int LAT = 3;
  localparam int IDW = 2;
`ifdef FLP_ADD_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {
    int id;
    logic [FW-1:0] p;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t e;
  logic [FW-1:0] opa [NREQ];
  logic [FW-1:0] opb [NREQ];
  logic [FW-1:0] esum [NREQ];
  logic [FW-1:0] pa [LAT];
  logic prev_acc = 1'b0;
  logic [FW-1:0] last_a = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  flp_add_sched_if #(.NREQ(NREQ), .FWIDTH(FW), .IDW(IDW)) bus ();
  flp_add_sched #(.NREQ(NREQ), .EWIDTH(8), .SWIDTH(23), .LATENCY(LAT), .IDW(IDW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  // adder stand-in: hand-computed sums for the operand pairs used below
  function automatic logic [FW-1:0] fadd(logic [FW-1:0] a, logic [FW-1:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h40400000;
      64'h3FC00000_3F000000: return 32'h40000000;
      64'h40000000_40000000: return 32'h40800000;
      64'h3F000000_3F000000: return 32'h3F800000;
      default: return 32'hFFC00000;
    endcase
  endfunction
  always @(posedge clk) begin
    pa[0] <= fadd(bus.o_add_a, bus.o_add_b);
    for (int k = 1; k < LAT; k++) pa[k] <= pa[k-1];
  end
  assign bus.i_add_p = pa[LAT-1];
  function automatic void chk(string name, logic [FW-1:0] act, logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endfunction
  always @(negedge clk) begin
    if (|bus.o_rsp_valid) begin
      if (q.size() == 0) chk("unexpected_rsp", FW'(bus.o_rsp_valid), '0);
      else begin
        e = q.pop_front();
        chk("rsp_valid", FW'(bus.o_rsp_valid), FW'(1 << e.id));
        chk("rsp_id", FW'(bus.o_rsp_id), FW'(e.id));
        chk("rsp_p", bus.o_rsp_p, e.p);
        chk("rsp_cycle", FW'(cyc), FW'(e.cyc));
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      chk("rsp_missing", FW'(bus.o_rsp_valid), FW'(1 << q[0].id));
      void'(q.pop_front());
    end
  end
  task automatic step(input logic [NREQ-1:0] v, input int g);
    @(negedge clk);
    chk("add_valid", FW'(bus.o_add_valid), FW'(prev_acc));
    chk("add_a", bus.o_add_a, last_a);
    bus.i_req_valid = v;
    for (int k = 0; k < NREQ; k++) begin
      bus.i_req_a[k*FW +: FW] = opa[k];
      bus.i_req_b[k*FW +: FW] = opb[k];
    end
    #1;
    chk("req_ready", FW'(bus.o_req_ready), g < 0 ? '0 : FW'(1 << g));
    prev_acc = g >= 0;
    if (g >= 0) begin
      last_a = opa[g];
      q.push_back('{g, esum[g], cyc + 1 + LAT});
    end
  endtask
  task automatic do_reset(input logic [NREQ-1:0] v);
    @(negedge clk);
    rst = 1'b1;
    bus.i_req_valid = v;
    #1;
    chk("ready_in_rst", FW'(bus.o_req_ready), '0);
    q.delete();
    prev_acc = 1'b0;
    last_a = '0;
    @(negedge clk);
    rst = 1'b0;
    bus.i_req_valid = '0;
    chk("rsp_after_rst", FW'(bus.o_rsp_valid), '0);
  endtask
  initial begin
    opa[0] = 32'h3F800000; opb[0] = 32'h40000000; esum[0] = 32'h40400000;
    opa[1] = 32'h3FC00000; opb[1] = 32'h3F000000; esum[1] = 32'h40000000;
    opa[2] = 32'h40000000; opb[2] = 32'h40000000; esum[2] = 32'h40800000;
    opa[3] = 32'h3F000000; opb[3] = 32'h3F000000; esum[3] = 32'h3F800000;
    bus.i_req_valid = '1;
    bus.i_req_a = '0;
    bus.i_req_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", FW'(bus.o_req_ready), '0);
    chk("rst_add_valid", FW'(bus.o_add_valid), '0);
    chk("rst_add_a", bus.o_add_a, '0);
    chk("rst_add_b", bus.o_add_b, '0);
    chk("rst_rsp_valid", FW'(bus.o_rsp_valid), '0);
    chk("rst_rsp_id", FW'(bus.o_rsp_id), '0);
    chk("rst_idle", FW'(bus.o_idle), 1);
    rst = 1'b0;
    bus.i_req_valid = '0;
    step(4'b0001, 0);
    repeat (3) step('0, -1);
    step('0, -1);
    chk("idle_busy", FW'(bus.o_idle), 0);
    step('0, -1);
    chk("idle_back", FW'(bus.o_idle), 1);
    for (int i = 0; i < 8; i++) step(4'b1111, RR ? (i + 1) % NREQ : 0);
    repeat (LAT + 2) step('0, -1);
    opa[2] = 32'h3FC00000; opb[2] = 32'h3F000000; esum[2] = 32'h40000000;
    step(4'b0100, 2);
    opa[2] = 32'h40000000; opb[2] = 32'h40000000; esum[2] = 32'h40800000;
    step(4'b0100, 2);
    repeat (LAT + 2) step('0, -1);
    repeat (3) step(4'b0010, 1);
    do_reset(4'b0010);
    repeat (3) begin
      step('0, -1);
      chk("rsp_after_rst", FW'(bus.o_rsp_valid), '0);
      chk("idle_after_rst", FW'(bus.o_idle), 1);
    end
    step(4'b1111, RR ? 1 : 0);
    repeat (LAT + 2) step('0, -1);
    repeat (3) begin
      step(4'b1000, 3);
      step('0, -1);
      step('0, -1);
    end
    repeat (6) step(4'b0010, 1);
    repeat (LAT + 3) step('0, -1);
    chk("queue_drained", FW'(q.size()), '0);
    chk("idle_end", FW'(bus.o_idle), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
